// File: rtl/dsel_mch_data_handle.sv
// N-channel write arbiter feeding a single-write/single-read RAM.
// Writes pass through a one-entry stage register before landing in the RAM;
// reads are registered and bypass the stage on an address match so a read
// issued right after a write always sees the new word.
module dsel_mch_data_handle #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           wr_en,
  input  logic [NCH*AWIDTH-1:0]    wr_addr,
  input  logic [NCH*DWIDTH-1:0]    wr_data,
  output logic [NCH-1:0]           wr_ready,
  input  logic [31:0]              reg_value,
  input  logic                     rd_en,
  input  logic [AWIDTH-1:0]        rd_addr,
  output logic [DWIDTH-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW1   = PW + 1;
  localparam int unsigned DEPTH = 1 << AWIDTH;

  // One staged write: flag, target address and word.
  typedef struct packed {
    logic              valid;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } stage_t;

  logic              arb_mode;
  logic              data_inv;
  logic [3:0]        fix_sel;
  logic              unused_reg_bits;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     cand;
  logic [PW1-1:0]    sum;
  logic              gnt_any;
  logic [NCH-1:0]    grant;
  logic              accept;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_data;
  logic [PW-1:0]     rr_next;

  stage_t            stage;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_word;
  logic              rd_hit;

  // Control word decode.
  assign arb_mode        = reg_value[0];
  assign data_inv        = reg_value[1];
  assign fix_sel         = reg_value[7:4];
  assign unused_reg_bits = ^{reg_value[31:8], reg_value[3:2]};

  // Pick the winning channel: circular search from rr_ptr, or the fixed index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    if (arb_mode) begin
      for (int k = 0; k < int'(NCH); k++) begin
        sum = PW1'(rr_ptr) + PW1'(k);
        if (sum >= PW1'(NCH)) begin
          sum = sum - PW1'(NCH);
        end
        cand = sum[PW-1:0];
        if (!gnt_any && wr_en[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else begin
      // Full 4-bit compare, so an index >= NCH matches nothing and stalls all.
      for (int i = 0; i < int'(NCH); i++) begin
        if (!gnt_any && (fix_sel == 4'(i)) && wr_en[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end

  // One-hot grant, forced low while reset is asserted.
  always_comb begin
    grant = '0;
    if (gnt_any && rst_n) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign wr_ready = grant;
  assign accept   = |grant;

  // Route the granted channel's address and data toward the stage.
  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (grant[i]) begin
        acc_addr = wr_addr[i*AWIDTH +: AWIDTH];
        acc_data = wr_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Pointer advances to the channel after the winner, wrapping at NCH.
  assign rr_next = (gnt_idx == PW'(NCH - 1)) ? '0 : PW'(gnt_idx + 1'b1);

  // Round-robin pointer; only accepted round-robin writes move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && arb_mode) begin
      rr_ptr <= rr_next;
    end
  end

  // Write stage; reset clears the flag so an in-flight write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage.valid <= accept;
      if (accept) begin
        stage.addr <= acc_addr;
        stage.data <= acc_data;
      end
    end
  end

  // RAM write port, fed from the stage; contents are not reset.
  always_ff @(posedge clk) begin
    if (stage.valid) begin
      mem[stage.addr] <= stage.data;
    end
  end

  // Write-first bypass when the staged write targets the read address.
  assign rd_hit  = stage.valid && (stage.addr == rd_addr);
  assign rd_word = rd_hit ? stage.data : mem[rd_addr];

  // Registered read port; inversion is taken from the control word at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= data_inv ? ~rd_word : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dsel_mch_data_handle.sv
// Self-checking bench for dsel_mch_data_handle: grant patterns checked inline,
// read data checked by a scoreboard queue filled at read issue.
module tb_dsel_mch_data_handle;

  localparam int NCH = 4;
  localparam int AW  = 5;
  localparam int DW  = 32;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    wr_en;
  logic [NCH*AW-1:0] wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [NCH-1:0]    wr_ready;
  logic [31:0]       reg_value;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  dsel_mch_data_handle #(.NCH(NCH), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .reg_value (reg_value),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every rd_valid pops one expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_valid_unexpected: rd_data=%h with no read pending", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_bad++;
          $display("FAIL rd_data: got %h expected %h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  // Record an accepted write from channel i in the reference memory.
  task automatic accept(input int i);
    model[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(reg_value[1] ? ~model[a] : model[a]);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en     = 4'hF;
    reg_value = 32'h20;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_wr_ready: got %b expected 0000", wr_ready); end
    n_cmp++;
    if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    wr_en = '0;
    repeat (2) @(posedge clk);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    reg_value = 32'h20;
    for (int i = 0; i < NCH; i++) set_ch(i, 5'(i + 1), 32'hA5A5_0000 + 32'(i + 1));
    wr_en = 4'hF;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0100) begin n_bad++; $display("FAIL fixed_grant: got %b expected 0100", wr_ready); end
    accept(2);
    tick();
    wr_en = '0;
    tick();
    issue_read(5'd3);
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL fixed_rd_latency: rd_valid=%b expected 1", rd_valid); end
    n_cmp++;
    if (rd_data !== 32'hA5A5_0003) begin n_bad++; $display("FAIL fixed_rd_data: got %h expected a5a50003", rd_data); end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
    n_cmp++;
    if (rd_data !== 32'hA5A5_0003) begin n_bad++; $display("FAIL rd_data_hold: got %h expected a5a50003", rd_data); end
    // Selected channel idle while others request: nothing granted.
    reg_value = 32'h00;
    wr_en     = 4'b1110;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0000) begin n_bad++; $display("FAIL fixed_sel_idle: got %b expected 0000", wr_ready); end
    wr_en = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int          seq [5];
    logic [3:0]  e;
    int          g;
    seq = '{0, 1, 2, 3, 0};
    reg_value = 32'h1;
    for (int i = 0; i < NCH; i++) set_ch(i, 5'(10 + i), 32'hC0DE_0000 + 32'(i));
    wr_en = 4'hF;
    for (int n = 0; n < 5; n++) begin
      g = seq[n];
      e = 4'b0001 << g;
      #1;
      n_cmp++;
      if (wr_ready !== e) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, wr_ready, e); end
      accept(g);
      tick();
      set_ch(g, wr_addr[g*AW +: AW], wr_data[g*DW +: DW] + 32'h100);
    end
    wr_en = '0;
    for (int a = 10; a < 14; a++) issue_read(5'(a));
    tick();
  endtask

  task automatic test_rr_skip();
    set_ch(0, 5'd20, 32'h0BAD_0020);
    set_ch(1, 5'd21, 32'h0BAD_0021);
    set_ch(3, 5'd23, 32'h0BAD_0023);
    wr_en = 4'b1001;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b1000) begin n_bad++; $display("FAIL rr_skip_first: got %b expected 1000", wr_ready); end
    accept(3);
    tick();
    wr_en = 4'b0001;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_skip_second: got %b expected 0001", wr_ready); end
    accept(0);
    tick();
    // Pointer should now sit at 1, so ch1 beats ch0.
    wr_en = 4'b0011;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0010) begin n_bad++; $display("FAIL rr_ptr_after_skip: got %b expected 0010", wr_ready); end
    accept(1);
    tick();
    wr_en = '0;
    issue_read(5'd20);
    issue_read(5'd21);
    issue_read(5'd23);
    tick();
  endtask

  task automatic test_collision();
    reg_value = 32'h0;
    set_ch(0, 5'd7, 32'h1234_5678);
    wr_en = 4'b0001;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0001) begin n_bad++; $display("FAIL coll_grant: got %b expected 0001", wr_ready); end
    accept(0);
    tick();
    wr_en = '0;
    issue_read(5'd7);
    reg_value = 32'h2;
    wr_en = 4'b0001;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0001) begin n_bad++; $display("FAIL coll_inv_grant: got %b expected 0001", wr_ready); end
    accept(0);
    tick();
    wr_en = '0;
    issue_read(5'd7);
    // Dropping data_inv after issue must not disturb the registered word.
    reg_value = 32'h0;
    #1;
    n_cmp++;
    if (rd_data !== 32'hEDCB_A987) begin n_bad++; $display("FAIL coll_inv_data: got %h expected edcba987", rd_data); end
    tick();
    n_cmp++;
    if (rd_data !== 32'hEDCB_A987) begin n_bad++; $display("FAIL inv_hold: got %h expected edcba987", rd_data); end
  endtask

  task automatic test_out_of_range();
    reg_value = 32'h90;
    for (int i = 0; i < NCH; i++) set_ch(i, 5'd3, 32'hDEAD_0000 + 32'(i));
    wr_en = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_cmp++;
      if (wr_ready !== 4'b0000) begin n_bad++; $display("FAIL oor_sel9[%0d]: got %b expected 0000", n, wr_ready); end
      tick();
    end
    reg_value = 32'h40;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0000) begin n_bad++; $display("FAIL oor_sel4: got %b expected 0000", wr_ready); end
    wr_en = '0;
    tick();
    tick();
    issue_read(5'd3);
    tick();
  endtask

  task automatic test_reset_mid_op();
    reg_value = 32'h0;
    set_ch(0, 5'd4, 32'h1111_1111);
    wr_en = 4'b0001;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_pre_grant: got %b expected 0001", wr_ready); end
    accept(0);
    tick();
    wr_en = '0;
    tick();
    tick();
    // Overwrite addr 4 and read it in the same cycle, then reset before the RAM write.
    set_ch(0, 5'd4, 32'h2222_2222);
    wr_en   = 4'b0001;
    rd_en   = 1'b1;
    rd_addr = 5'd4;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_grant: got %b expected 0001", wr_ready); end
    tick();
    wr_en = '0;
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b expected 1", rd_valid); end
    n_cmp++;
    if (rd_data !== 32'h1111_1111) begin n_bad++; $display("FAIL rst_pre_data: got %h expected 11111111", rd_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rd_data: got %h expected 0", rd_data); end
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rd_valid: got %b expected 0", rd_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Pointer back at 0: ch1 must win over ch3.
    reg_value = 32'h1;
    set_ch(1, 5'd6, 32'h6666_0006);
    set_ch(3, 5'd8, 32'h8888_0008);
    wr_en = 4'b1010;
    #1;
    n_cmp++;
    if (wr_ready !== 4'b0010) begin n_bad++; $display("FAIL rst_rr_ptr: got %b expected 0010", wr_ready); end
    accept(1);
    tick();
    wr_en = '0;
    tick();
    issue_read(5'd4);
    issue_read(5'd6);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    reg_value = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    #3;
    test_reset();
    test_fixed();
    test_round_robin();
    test_rr_skip();
    test_collision();
    test_out_of_range();
    test_reset_mid_op();
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reads_outstanding: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsel_mch_data_handle.md
Name: dsel_mch_data_handle

Overview:
N-channel successor of the two-channel data-select/SRAM block. It arbitrates NCH write channels into one internal single-port-write, single-port-read RAM of depth 2**AWIDTH, using either fixed-channel or round-robin selection. It exposes a ready/enable write handshake per channel and a registered read port with valid flag and optional data inversion. It sits between the per-channel data producers and the downstream reader in the dsel subsystem; control comes from a 32-bit register word.

Parameters:
NCH, 4, number of write channels (2..16)
AWIDTH, 5, RAM address width; depth = 2**AWIDTH
DWIDTH, 32, data width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  NCH  per-channel write request
wr_addr  input  NCH*AWIDTH  channel i address at [i*AWIDTH +: AWIDTH]
wr_data  input  NCH*DWIDTH  channel i data at [i*DWIDTH +: DWIDTH]
wr_ready  output  NCH  one-hot grant; write accepted when wr_en[i] & wr_ready[i]
reg_value  input  32  [0] arb_mode (0 fixed, 1 round-robin); [1] data_inv; [7:4] fixed channel index; others ignored
rd_en  input  1  read request
rd_addr  input  AWIDTH  read address
rd_data  output  DWIDTH  read data, registered
rd_valid  output  1  rd_data valid, one-cycle pulse per read

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. During reset: rd_data=0, rd_valid=0, rr_ptr=0, stage valid=0, wr_ready=0. RAM contents are not reset.
- Grant logic (combinational from wr_en, reg_value, rr_ptr):
  - Fixed mode: wr_ready[sel] = wr_en[sel] only for sel = reg_value[7:4]. If sel >= NCH, no channel is granted, so all writes stall.
  - Round-robin mode: grant the first requesting channel, searching circularly from rr_ptr. At most one grant per cycle. Zero grants when wr_en is all zero.
- rr_ptr: on an accepted write in round-robin mode, rr_ptr <= (granted index + 1) mod NCH. It holds otherwise, including in fixed mode. Mode switches do not reset rr_ptr.
- Write pipeline:
  - Accept at cycle T: stage register captures {valid, addr, data} at edge T.
  - RAM is written at edge T+1 from the stage register.
  - Stage valid deasserts in any cycle with no accept.
  - Sustained throughput: one write per cycle.
- Read:
  - rd_en sampled at edge T. rd_data and rd_valid update at edge T, so they are visible in cycle T+1. rd_valid=1 for exactly one cycle per rd_en.
  - rd_data holds its last value when rd_en=0.
- Read/write collision: if rd_en is high while stage valid is high and stage addr == rd_addr, rd_data returns the stage data (write-first bypass), not stale RAM contents.
- Inversion: data_inv is sampled at read issue. rd_data = data_inv ? ~word : word. Changing data_inv does not alter an already-registered rd_data.
- Unwritten RAM locations read as X. The bench must write a location before reading it.
- Simultaneous events:
  - Multiple wr_en in fixed mode: only sel is accepted; others see wr_ready=0 and must hold their request.
  - rd_en and an accept in the same cycle are independent.
- Reset mid-operation: a staged write is discarded (RAM is not written). A pending rd_valid is cleared. rr_ptr returns to 0.
- Address widths are exact; no wrap or truncation logic. Channel index compare uses the full 4-bit field.

Test Plan:
- Fixed mode, reg_value=0x20 (sel=2): wr_en=4'b1111, ch2 addr=3 data=0xA5A5_0003 -> only wr_ready[2]=1. After 2 cycles, read addr 3 -> rd_data=0xA5A5_0003 with rd_valid one cycle after rd_en.
- Round-robin, reg_value=0x1: all four channels request continuously, each with a distinct addr/data -> grants 0,1,2,3,0 on consecutive cycles. Every granted word reads back correctly.
- Round-robin skip: rr_ptr=1, only ch0 and ch3 request -> ch3 granted first, then ch0. rr_ptr ends at 1.
- Collision: accept write addr 7 data 0x1234_5678, then rd_en addr 7 in the next cycle -> rd_data=0x1234_5678 (bypass). Repeat with reg_value[1]=1 -> rd_data=0xEDCB_A987.
- Fixed sel=9 (out of range, NCH=4): wr_en=4'hF for 5 cycles -> wr_ready=0 throughout. A subsequent read of a previously written address is unchanged.
- Reset asserted in the cycle after a write accept to addr 4 (old value 0x1111_1111) -> rd_data=0 and rd_valid=0 immediately. After reset, reading addr 4 returns 0x1111_1111.
